// File: rtl/pll_reset_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold count values 0 .. n-1 (never less than 1).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, retries on
// timeout and releases sys_rst once lock has been stable long enough.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             reset_req,
    input  logic             clr_status,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic [1:0]       state,
    output logic             lock_lost,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam int CW = cnt_width(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic            locked_s;
    logic            fail_ev;
    logic            lost_ev;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        nxt     = cur;
        fail_ev = 1'b0;
        lost_ev = 1'b0;
        if (reset_req) begin
            nxt = PLL_RST;
        end else begin
            unique case (cur)
                PLL_RST: begin
                    if (cnt == RST_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        nxt = STABLE;
                    end else if (cnt == TO_LAST) begin
                        nxt     = PLL_RST;
                        fail_ev = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) nxt = WAIT_LOCK;
                    else if (cnt == STABLE_LAST) nxt = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        nxt     = PLL_RST;
                        lost_ev = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur <= PLL_RST;
        end else begin
            cur <= nxt;
        end
    end

    // reset_req must restart the count even when the state does not change.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reset_req || (nxt != cur)) begin
            cnt <= '0;
        end else if (cur != RUN) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Outputs decode the next state so they change on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
        end else begin
            pll_rst <= (nxt == PLL_RST);
            sys_rst <= (nxt != RUN);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_lost <= 1'b0;
            fail_cnt  <= '0;
            lost_cnt  <= '0;
        end else begin
            if (lost_ev) lock_lost <= 1'b1;
            else if (clr_status) lock_lost <= 1'b0;

            if (fail_ev) begin
                if (clr_status) fail_cnt <= CNT_W'(1);
                else if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end else if (clr_status) begin
                fail_cnt <= '0;
            end

            if (lost_ev) begin
                if (clr_status) lost_cnt <= CNT_W'(1);
                else if (lost_cnt != '1) lost_cnt <= lost_cnt + CNT_W'(1);
            end else if (clr_status) begin
                lost_cnt <= '0;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: vector table, corner sequences
// and a randomized run against a behavioural model.
module tb_pll_reset_seq;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int ST  = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          locked;
    logic          reset_req;
    logic          clr_status;
    logic          pll_rst;
    logic          sys_rst;
    logic [1:0]    state;
    logic          lock_lost;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (ST),
        .CNT_W         (CW)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .locked     (locked),
        .reset_req  (reset_req),
        .clr_status (clr_status),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .state      (state),
        .lock_lost  (lock_lost),
        .fail_cnt   (fail_cnt),
        .lost_cnt   (lost_cnt)
    );

    typedef struct {
        bit       lk;
        bit       rq;
        bit       cl;
        int       n;
        bit [1:0] st;
        bit       pr;
        bit       sr;
        bit       ll;
        int       lc;
        int       fc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        locked     = 1'b0;
        reset_req  = 1'b0;
        clr_status = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit [1:0] st, input bit pr,
                             input bit sr, input bit ll, input int lc, input int fc);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".pll_rst"}, 32'(pll_rst), 32'(pr));
        check({tag, ".sys_rst"}, 32'(sys_rst), 32'(sr));
        check({tag, ".lock_lost"}, 32'(lock_lost), 32'(ll));
        check({tag, ".lost_cnt"}, 32'(lost_cnt), 32'(lc));
        check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(fc));
    endtask

    // Behavioural model: phase number, cycles spent in the phase, and a
    // two-deep history of sampled locked values.
    int m_ph, m_age, m_fail, m_lost;
    bit m_flag, m_s1, m_s2;

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_fail = 0; m_lost = 0;
        m_flag = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step(input bit lk, input bit rq, input bit cl);
        bit ls, tmo, lose;
        int np;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        np = m_ph;
        tmo = 0;
        lose = 0;
        m_age++;
        if (rq) np = 0;
        else if (m_ph == 0) begin
            if (m_age == RST) np = 1;
        end else if (m_ph == 1) begin
            if (ls) np = 2;
            else if (m_age == TO) begin np = 0; tmo = 1; end
        end else if (m_ph == 2) begin
            if (!ls) np = 1;
            else if (m_age == ST) np = 3;
        end else if (!ls) begin
            np = 0;
            lose = 1;
        end
        if (rq || np != m_ph) m_age = 0;
        m_ph = np;
        if (cl) begin m_flag = 0; m_fail = 0; m_lost = 0; end
        if (tmo && m_fail < 15) m_fail++;
        if (lose) begin
            m_flag = 1;
            if (m_lost < 15) m_lost++;
        end
    endtask

    initial begin
        // lk rq cl  n  st pr sr ll lc fc
        vecs.push_back('{0, 0, 0,  3, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  1, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  6, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  2, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1, 2, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  7, 2, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  2, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  1, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 0,  4, 1, 0, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 0,  1, 2, 0, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 0,  7, 2, 0, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 0,  1, 3, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 1, 0,  1, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 1,  1, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  2, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1, 2, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  7, 2, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  2, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1,  1, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0,  2, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0,  1, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0,  3, 0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0,  1, 1, 0, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 19, 1, 0, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0,  1, 0, 1, 1, 1, 1, 1});

        do_reset();
        check_all("reset", 0, 1, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            locked     = vecs[i].lk;
            reset_req  = vecs[i].rq;
            clr_status = vecs[i].cl;
            repeat (vecs[i].n) tick();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr,
                      vecs[i].sr, vecs[i].ll, vecs[i].lc, vecs[i].fc);
        end
        reset_req  = 1'b0;
        clr_status = 1'b0;

        // Retry loop with locked held low: one retry per RST+TO cycles.
        for (int k = 2; k <= 16; k++) begin
            repeat (RST + TO) tick();
            check($sformatf("retry%0d.fail_cnt", k), 32'(fail_cnt),
                  32'((k > 15) ? 15 : k));
            check($sformatf("retry%0d.state", k), 32'(state), 32'd0);
            check($sformatf("retry%0d.sys_rst", k), 32'(sys_rst), 32'd1);
        end

        // Lock glitch while in STABLE restarts qualification.
        do_reset();
        repeat (RST) tick();
        check("glitch.wait", 32'(state), 32'd1);
        locked = 1'b1;
        repeat (5) tick();
        check("glitch.stable", 32'(state), 32'd2);
        locked = 1'b0;
        repeat (2) tick();
        check("glitch.hold", 32'(state), 32'd2);
        tick();
        check("glitch.back", 32'(state), 32'd1);
        locked = 1'b1;
        repeat (3) tick();
        check("glitch.restable", 32'(state), 32'd2);
        repeat (ST - 1) tick();
        check("glitch.not_yet", 32'(sys_rst), 32'd1);
        tick();
        check("glitch.run", 32'(state), 32'd3);
        check("glitch.sys_rst", 32'(sys_rst), 32'd0);

        // Asynchronous reset between edges while in STABLE.
        do_reset();
        repeat (RST) tick();
        locked = 1'b1;
        repeat (5) tick();
        check("async.pre", 32'(state), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_all("async", 0, 1, 1, 0, 0, 0);
        #2;
        rst = 1'b0;

        // Randomized run against the behavioural model.
        do_reset();
        model_reset();
        begin
            int  run;
            bit  lk;
            run = 0;
            lk  = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (run == 0) begin
                    lk = !lk;
                    if (lk) run = $urandom_range(1, 80);
                    else if ($urandom_range(0, 3) == 0) run = $urandom_range(21, 45);
                    else run = $urandom_range(1, 6);
                end
                run--;
                locked     = lk;
                reset_req  = ($urandom_range(0, 199) == 0);
                clr_status = ($urandom_range(0, 39) == 0);
                tick();
                model_step(locked, reset_req, clr_status);
                check($sformatf("rand%0d", c),
                      32'({state, pll_rst, sys_rst, lock_lost, fail_cnt, lost_cnt}),
                      32'({m_ph[1:0], m_ph == 0, m_ph != 3, m_flag,
                           m_fail[3:0], m_lost[3:0]}));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
